// File: rtl/pong_play_ctl.sv
// PONG game sequencer: steps the ball once per frame, handles wall and paddle
// bounces, scoring and lives, and the IDLE/PLAY/MISS/SERVE/OVER click flow.
module pong_play_ctl #(
  parameter int SCREEN_W  = 800,
  parameter int SCREEN_H  = 600,
  parameter int BALL_SIZE = 16,
  parameter int PADDLE_X  = 32,
  parameter int PADDLE_H  = 100,
  parameter int STEP      = 4,
  parameter int LIVES     = 3,
  parameter int SERVE_X   = 400,
  parameter int SERVE_Y   = 300
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vblnk_in,
  input  logic        mouse_left,
  input  logic [11:0] paddle_ypos,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic [7:0]  score,
  output logic [1:0]  lives,
  output logic        serve_pending,
  output logic        game_over
);

  typedef enum logic [2:0] {IDLE, PLAY, MISS, SERVE, OVER} state_t;

  localparam logic [12:0] XMAX   = 13'(SCREEN_W - BALL_SIZE);
  localparam logic [12:0] YMAX   = 13'(SCREEN_H - BALL_SIZE);
  localparam logic [12:0] STP    = 13'(STEP);
  localparam logic [12:0] PX     = 13'(PADDLE_X);
  localparam logic [12:0] PH     = 13'(PADDLE_H);
  localparam logic [12:0] BS     = 13'(BALL_SIZE);
  localparam logic [11:0] SX     = 12'(SERVE_X);
  localparam logic [11:0] SY     = 12'(SERVE_Y);
  localparam logic [1:0]  LIVES0 = 2'(LIVES);

  state_t      state;
  logic        vblnk_q, mouse_q;
  logic        dir_right, dir_down;
  logic        tick, click;
  logic [12:0] x13, y13, p13;
  logic [12:0] x_nxt, y_nxt;
  logic        dx_nxt, dy_nxt;
  logic        hit, miss;

  // Both axes are evaluated from the current position so a corner flips both.
  always_comb begin
    tick   = vblnk_in & ~vblnk_q;
    click  = mouse_left & ~mouse_q;
    x13    = {1'b0, xpos};
    y13    = {1'b0, ypos};
    p13    = {1'b0, paddle_ypos};
    y_nxt  = y13;
    dy_nxt = dir_down;
    x_nxt  = x13;
    dx_nxt = dir_right;
    hit    = 1'b0;
    miss   = 1'b0;

    if (dir_down) begin
      if (y13 + STP >= YMAX) begin
        y_nxt  = YMAX;
        dy_nxt = 1'b0;
      end else begin
        y_nxt = y13 + STP;
      end
    end else begin
      if (y13 <= STP) begin
        y_nxt  = '0;
        dy_nxt = 1'b1;
      end else begin
        y_nxt = y13 - STP;
      end
    end

    if (dir_right) begin
      if (x13 + STP >= XMAX) begin
        x_nxt  = XMAX;
        dx_nxt = 1'b0;
      end else begin
        x_nxt = x13 + STP;
      end
    end else begin
      hit  = (x13 > PX) && (x13 <= PX + STP) &&
             (y13 + BS > p13) && (y13 < p13 + PH);
      miss = !hit && (x13 <= STP);
      if (hit) begin
        x_nxt  = PX;
        dx_nxt = 1'b1;
      end else if (miss) begin
        x_nxt = '0;
      end else begin
        x_nxt = x13 - STP;
      end
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state         <= IDLE;
      vblnk_q       <= 1'b0;
      mouse_q       <= 1'b0;
      xpos          <= SX;
      ypos          <= SY;
      dir_right     <= 1'b0;
      dir_down      <= 1'b1;
      score         <= '0;
      lives         <= LIVES0;
      serve_pending <= 1'b1;
      game_over     <= 1'b0;
    end else begin
      vblnk_q <= vblnk_in;
      mouse_q <= mouse_left;
      case (state)
        IDLE, SERVE: begin
          if (click) begin
            state         <= PLAY;
            serve_pending <= 1'b0;
          end
        end
        PLAY: begin
          if (tick) begin
            xpos      <= x_nxt[11:0];
            ypos      <= y_nxt[11:0];
            dir_right <= dx_nxt;
            dir_down  <= dy_nxt;
            if (hit && score != 8'hFF) score <= score + 8'd1;
            if (miss) state <= MISS;
          end
        end
        MISS: begin
          lives     <= lives - 2'd1;
          xpos      <= SX;
          ypos      <= SY;
          dir_right <= 1'b0;
          if (lives == 2'd1) begin
            state     <= OVER;
            game_over <= 1'b1;
          end else begin
            state         <= SERVE;
            serve_pending <= 1'b1;
          end
        end
        OVER: begin
          // Restart goes to IDLE only; a second click is needed to serve.
          if (click) begin
            state         <= IDLE;
            score         <= '0;
            lives         <= LIVES0;
            game_over     <= 1'b0;
            serve_pending <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pong_play_ctl.sv
// Scoreboarded random + directed bench for pong_play_ctl against a frame-level
// game model kept in the bench.
module tb_pong_play_ctl;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        vblnk_in = 1'b0;
  logic        mouse_left = 1'b0;
  logic [11:0] paddle_ypos = '0;
  logic [11:0] xpos, ypos;
  logic [7:0]  score;
  logic [1:0]  lives;
  logic        serve_pending, game_over;

  pong_play_ctl dut (
    .pclk(pclk), .rst(rst), .vblnk_in(vblnk_in), .mouse_left(mouse_left),
    .paddle_ypos(paddle_ypos), .xpos(xpos), .ypos(ypos), .score(score),
    .lives(lives), .serve_pending(serve_pending), .game_over(game_over)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int x, y, sc, lv, sp, go;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   errors  = 0;

  // Game model: phase names instead of encodings, directions as +1/-1.
  typedef enum {G_IDLE, G_PLAY, G_MISS, G_SERVE, G_OVER} phase_t;
  phase_t ph;
  int mx, my, mdx, mdy, msc, mlv, prev_vb, prev_ms;
  logic m = 1'b0;

  task automatic model_step(input bit vb, input bit ms, input int pad, input bit r);
    bit tk, ck;
    int ny, nx;
    if (r) begin
      ph = G_IDLE; mx = 400; my = 300; mdx = -1; mdy = 1; msc = 0; mlv = 3;
      prev_vb = 0; prev_ms = 0;
      return;
    end
    tk = vb && !prev_vb;
    ck = ms && !prev_ms;
    prev_vb = vb;
    prev_ms = ms;
    case (ph)
      G_IDLE, G_SERVE: if (ck) ph = G_PLAY;
      G_PLAY: if (tk) begin
        ny = my + 4 * mdy;
        if (mdy > 0 && ny >= 584) begin ny = 584; mdy = -1; end
        else if (mdy < 0 && my <= 4) begin ny = 0; mdy = 1; end
        if (mdx > 0) begin
          nx = mx + 4;
          if (nx >= 784) begin nx = 784; mdx = -1; end
        end else if (mx > 32 && mx <= 36 && my + 16 > pad && my < pad + 100) begin
          nx = 32; mdx = 1;
          if (msc < 255) msc++;
        end else if (mx <= 4) begin
          nx = 0; ph = G_MISS;
        end else begin
          nx = mx - 4;
        end
        mx = nx; my = ny;
      end
      G_MISS: begin
        mlv--; mx = 400; my = 300; mdx = -1;
        ph = (mlv == 0) ? G_OVER : G_SERVE;
      end
      G_OVER: if (ck) begin ph = G_IDLE; msc = 0; mlv = 3; end
      default: ;
    endcase
  endtask

  // One clock of stimulus, entered and left on a negedge.
  task automatic drive(input bit vb, input bit ms, input int pad, input bit r);
    exp_t e;
    vblnk_in = vb; mouse_left = ms; paddle_ypos = 12'(pad); rst = r;
    model_step(vb, ms, pad, r);
    e.x = mx; e.y = my; e.sc = msc; e.lv = mlv;
    e.sp = (ph == G_IDLE || ph == G_SERVE) ? 1 : 0;
    e.go = (ph == G_OVER) ? 1 : 0;
    q.push_back(e);
    @(negedge pclk);
  endtask

  int pad_v = 0;
  task automatic tick();
    drive(1'b1, m, pad_v, 1'b0);
    drive(1'b0, m, pad_v, 1'b0);
  endtask
  task automatic click();
    m = 1'b0; drive(1'b0, m, pad_v, 1'b0);
    m = 1'b1; drive(1'b0, m, pad_v, 1'b0);
  endtask

  task automatic chk(input string name, input int act, input int exp_v);
    vectors++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Monitor: one scoreboard entry per elapsed rising edge.
  initial begin
    forever begin
      @(posedge pclk);
      #1;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        vectors++;
        if (xpos != 12'(e.x) || ypos != 12'(e.y) || score != 8'(e.sc) ||
            lives != 2'(e.lv) || serve_pending != e.sp[0] || game_over != e.go[0]) begin
          errors++;
          $display("FAIL scoreboard t=%0t: got x=%0d y=%0d sc=%0d lv=%0d sp=%0b go=%0b expected x=%0d y=%0d sc=%0d lv=%0d sp=%0d go=%0d",
                   $time, xpos, ypos, score, lives, serve_pending, game_over,
                   e.x, e.y, e.sc, e.lv, e.sp, e.go);
        end
      end
    end
  end

  initial begin
    int guard;
    @(negedge pclk);
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 1);
    chk("reset_x", xpos, 400);
    chk("reset_lives", lives, 3);
    chk("reset_sp", serve_pending, 1);
    chk("reset_go", game_over, 0);

    repeat (10) tick();
    chk("idle_ticks_x", xpos, 400);
    chk("idle_ticks_y", ypos, 300);
    chk("idle_ticks_sp", serve_pending, 1);

    pad_v = 450;
    click();
    tick();
    chk("first_tick_x", xpos, 396);
    chk("first_tick_y", ypos, 304);
    chk("first_tick_sp", serve_pending, 0);
    repeat (70) tick();
    chk("bottom_clamp_y", ypos, 584);
    tick();
    chk("bottom_bounce_y", ypos, 580);
    repeat (20) tick();
    chk("paddle_hit_x", xpos, 32);
    chk("paddle_hit_score", score, 1);
    tick();
    chk("after_hit_x", xpos, 36);

    drive(0, 0, 0, 1);
    pad_v = 0;
    click();
    repeat (99) tick();
    drive(1'b1, m, pad_v, 1'b0);
    chk("miss_x", xpos, 0);
    drive(1'b0, m, pad_v, 1'b0);
    chk("miss_lives", lives, 2);
    chk("miss_serve_x", xpos, 400);
    chk("miss_serve_y", ypos, 300);
    chk("miss_sp", serve_pending, 1);

    pad_v = 4000;
    guard = 0;
    while (game_over !== 1'b1 && guard < 1000) begin
      if (serve_pending) click();
      tick();
      guard++;
    end
    chk("over_reached", game_over, 1);
    chk("over_lives", lives, 0);
    click();
    chk("restart_lives", lives, 3);
    chk("restart_score", score, 0);
    chk("restart_go", game_over, 0);
    chk("restart_sp", serve_pending, 1);

    click();
    repeat (20) tick();
    drive(0, m, pad_v, 1);
    chk("midplay_rst_x", xpos, 400);
    chk("midplay_rst_sp", serve_pending, 1);

    begin
      bit vb = 0;
      bit r;
      for (int i = 0; i < 6000; i++) begin
        if ($urandom_range(3) == 0) vb = ~vb;
        if ($urandom_range(40) == 0) m = ~m;
        if ($urandom_range(200) == 0) pad_v = $urandom_range(600);
        r = ($urandom_range(2000) == 0);
        drive(vb, m, pad_v, r);
      end
    end

    drive(0, 0, 0, 0);
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(negedge pclk);
      guard++;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
